// File: rtl/operand_bypass.sv
// ID/EX operand forwarding (EX > MEM > WB > regfile) with a one-bubble load-use interlock.
// Operands register one edge after sampling; stall_in holds all state, flush clears the slot and wins over everything.
module operand_bypass #(
    parameter int XLEN   = 32,
    parameter int NSRC   = 2,
    parameter int WB_FWD = 1,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [NSRC*5-1:0]      id_rs_addr,
    input  logic [NSRC-1:0]        id_rs_use,
    input  logic [NSRC*XLEN-1:0]   id_rs_data,
    input  logic                   ex_valid,
    input  logic                   ex_wen,
    input  logic                   ex_is_load,
    input  logic [4:0]             ex_rd,
    input  logic [XLEN-1:0]        ex_result,
    input  logic                   mem_valid,
    input  logic                   mem_wen,
    input  logic                   mem_is_load,
    input  logic [4:0]             mem_rd,
    input  logic [XLEN-1:0]        mem_alu,
    input  logic [XLEN-1:0]        mem_rdata,
    input  logic                   wb_valid,
    input  logic                   wb_wen,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   stall_in,
    input  logic                   flush,
    output logic [NSRC*XLEN-1:0]   op_data,
    output logic                   op_valid,
    output logic [NSRC*2-1:0]      fwd_src,
    output logic                   stall_out,
    output logic [CNT_W-1:0]       lu_stalls
);

    typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

    state_t                 state, state_nxt;
    logic [NSRC*XLEN-1:0]   fwd_data;
    logic [NSRC*2-1:0]      fwd_tag;
    logic [NSRC-1:0]        ld_hit;
    logic                   hazard;

    genvar g;
    for (g = 0; g < NSRC; g++) begin : g_src
        logic [4:0]      rs;
        logic            ex_hit, mem_hit, wb_hit;
        logic [XLEN-1:0] sel_data;
        logic [1:0]      sel_tag;

        assign rs      = id_rs_addr[5*g +: 5];
        assign ex_hit  = id_rs_use[g] && ex_valid  && ex_wen  && (ex_rd  == rs) && (rs != 5'd0);
        assign mem_hit = id_rs_use[g] && mem_valid && mem_wen && (mem_rd == rs) && (rs != 5'd0);
        assign wb_hit  = (WB_FWD != 0) && id_rs_use[g] && wb_valid && wb_wen &&
                         (wb_rd == rs) && (rs != 5'd0);

        always_comb begin
            sel_data = id_rs_data[g*XLEN +: XLEN];
            sel_tag  = 2'd0;
            if (ex_hit) begin
                sel_data = ex_result;
                sel_tag  = 2'd1;
            end else if (mem_hit) begin
                sel_data = mem_is_load ? mem_rdata : mem_alu;
                sel_tag  = 2'd2;
            end else if (wb_hit) begin
                sel_data = wb_data;
                sel_tag  = 2'd3;
            end
        end

        assign fwd_data[g*XLEN +: XLEN] = sel_data;
        assign fwd_tag[g*2 +: 2]        = sel_tag;
        // EX wins priority, so an EX load hit is always the selected producer
        assign ld_hit[g]                = ex_hit && ex_is_load;
    end

    assign hazard = |ld_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = RUN;
        else if (!stall_in) begin
            case (state)
                RUN:      state_nxt = stall_out ? LU_STALL : RUN;
                LU_STALL: state_nxt = RUN;
                default:  state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        stall_out = 1'b0;
        if (reset && (state == RUN) && !flush && !stall_in)
            stall_out = hazard && id_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_data  <= '0;
            op_valid <= 1'b0;
            fwd_src  <= '0;
        end else if (flush) begin
            op_data  <= '0;
            op_valid <= 1'b0;
            fwd_src  <= '0;
        end else if (!stall_in) begin
            if (stall_out) begin
                op_data  <= '0;
                op_valid <= 1'b0;
                fwd_src  <= '0;
            end else begin
                op_data  <= fwd_data;
                op_valid <= id_valid;
                fwd_src  <= fwd_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lu_stalls <= '0;
        else if (stall_out && (lu_stalls != {CNT_W{1'b1}}))
            lu_stalls <= lu_stalls + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_operand_bypass.sv
// Directed bench for operand_bypass: one instance with WB forwarding and a 2-bit stall counter,
// a second with WB forwarding disabled, both driven from the same stimulus.
module tb_operand_bypass;

    logic          clk;
    logic          reset;
    logic          id_valid;
    logic [9:0]    id_rs_addr;
    logic [1:0]    id_rs_use;
    logic [63:0]   id_rs_data;
    logic          ex_valid, ex_wen, ex_is_load;
    logic [4:0]    ex_rd;
    logic [31:0]   ex_result;
    logic          mem_valid, mem_wen, mem_is_load;
    logic [4:0]    mem_rd;
    logic [31:0]   mem_alu, mem_rdata;
    logic          wb_valid, wb_wen;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          stall_in, flush;

    logic [63:0]   op_data,  nw_op_data;
    logic          op_valid, nw_op_valid;
    logic [3:0]    fwd_src,  nw_fwd_src;
    logic          stall_out, nw_stall_out;
    logic [1:0]    lu_stalls;
    logic [15:0]   nw_lu_stalls;

    int errors = 0;
    int checks = 0;
    int exp_lu = 0;

    operand_bypass #(.XLEN(32), .NSRC(2), .WB_FWD(1), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_use(id_rs_use), .id_rs_data(id_rs_data),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_result(ex_result), .mem_valid(mem_valid), .mem_wen(mem_wen),
        .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_alu(mem_alu), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_in(stall_in), .flush(flush), .op_data(op_data), .op_valid(op_valid),
        .fwd_src(fwd_src), .stall_out(stall_out), .lu_stalls(lu_stalls)
    );

    operand_bypass #(.XLEN(32), .NSRC(2), .WB_FWD(0), .CNT_W(16)) dut_nowb (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rs_use(id_rs_use), .id_rs_data(id_rs_data),
        .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_result(ex_result), .mem_valid(mem_valid), .mem_wen(mem_wen),
        .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_alu(mem_alu), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_in(stall_in), .flush(flush), .op_data(nw_op_data), .op_valid(nw_op_valid),
        .fwd_src(nw_fwd_src), .stall_out(nw_stall_out), .lu_stalls(nw_lu_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        exp_lu = (exp_lu < 3) ? exp_lu + 1 : 3;
    endtask

    task automatic clr();
        id_valid = 0; id_rs_addr = '0; id_rs_use = '0; id_rs_data = '0;
        ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_rd = '0; ex_result = '0;
        mem_valid = 0; mem_wen = 0; mem_is_load = 0; mem_rd = '0; mem_alu = '0; mem_rdata = '0;
        wb_valid = 0; wb_wen = 0; wb_rd = '0; wb_data = '0;
        stall_in = 0; flush = 0;
    endtask

    // decode reads x7 (operand1) and x1 (operand0) while EX holds a load to x7
    task automatic set_hazard();
        clr();
        id_valid = 1; id_rs_use = 2'b11; id_rs_addr = {5'd7, 5'd1};
        id_rs_data = {32'h70, 32'h10};
        ex_valid = 1; ex_wen = 1; ex_is_load = 1; ex_rd = 5'd7; ex_result = 32'h1234;
    endtask

    task automatic lu_event(input string tag);
        set_hazard();
        #1 check({tag, "_stall_req"}, stall_out, 1);
        step(); bump();
        check({tag, "_bubble_valid"}, op_valid, 0);
        check({tag, "_bubble_data"}, op_data, 0);
        check({tag, "_count"}, lu_stalls, exp_lu);
        ex_valid = 0; ex_is_load = 0;
        mem_valid = 1; mem_wen = 1; mem_is_load = 1; mem_rd = 5'd7;
        mem_rdata = 32'hDEAD; mem_alu = 32'hBAD;
        #1 check({tag, "_no_restall"}, stall_out, 0);
        step();
        check({tag, "_load_data"}, op_data, {32'hDEAD, 32'h10});
        check({tag, "_load_tag"}, fwd_src, 4'b1000);
        check({tag, "_load_valid"}, op_valid, 1);
    endtask

    initial begin
        reset = 0;
        set_hazard();
        #12;
        check("rst_op_data", op_data, 0);
        check("rst_op_valid", op_valid, 0);
        check("rst_fwd_src", fwd_src, 0);
        check("rst_lu_stalls", lu_stalls, 0);
        check("rst_stall_out", stall_out, 0);
        #11 reset = 1;
        clr();

        // plain regfile read
        id_valid = 1; id_rs_use = 2'b11; id_rs_addr = {5'd2, 5'd1}; id_rs_data = {32'h22, 32'h11};
        step();
        check("nohaz_data", op_data, {32'h22, 32'h11});
        check("nohaz_tag", fwd_src, 0);
        check("nohaz_valid", op_valid, 1);

        // priority: x5 produced in EX, MEM and WB
        id_rs_addr = {5'd3, 5'd5}; id_rs_data = {32'h33, 32'h55};
        ex_valid = 1; ex_wen = 1; ex_rd = 5'd5; ex_result = 32'hA;
        mem_valid = 1; mem_wen = 1; mem_rd = 5'd5; mem_alu = 32'hB; mem_rdata = 32'hF0;
        wb_valid = 1; wb_wen = 1; wb_rd = 5'd5; wb_data = 32'hC;
        step();
        check("prio_ex_data", op_data, {32'h33, 32'hA});
        check("prio_ex_tag", fwd_src, 4'b0001);
        check("prio_ex_nowb_data", nw_op_data, {32'h33, 32'hA});
        ex_valid = 0;
        step();
        check("prio_mem_data", op_data, {32'h33, 32'hB});
        check("prio_mem_tag", fwd_src, 4'b0010);
        mem_valid = 0;
        step();
        check("prio_wb_data", op_data, {32'h33, 32'hC});
        check("prio_wb_tag", fwd_src, 4'b0011);
        check("nowb_data", nw_op_data, {32'h33, 32'h55});
        check("nowb_tag", nw_fwd_src, 0);
        id_rs_addr = {5'd5, 5'd5}; id_rs_use = 2'b01;
        step();
        check("unused_op_data", op_data, {32'h33, 32'hC});
        check("unused_op_tag", fwd_src, 4'b0011);
        id_rs_use = 2'b11;
        step();
        check("same_reg_data", op_data, {32'hC, 32'hC});
        check("same_reg_tag", fwd_src, 4'b1111);

        // x0 never forwards
        clr();
        id_valid = 1; id_rs_use = 2'b11; id_rs_addr = {5'd4, 5'd0}; id_rs_data = {32'h44, 32'h0};
        ex_valid = 1; ex_wen = 1; ex_rd = 5'd0; ex_result = 32'h99;
        step();
        check("x0_data", op_data, {32'h44, 32'h0});
        check("x0_tag", fwd_src, 0);

        lu_event("lu");

        // stall_in freezes outputs even with changing inputs
        clr();
        id_valid = 1; id_rs_use = 2'b11; id_rs_addr = {5'd2, 5'd1}; id_rs_data = {32'h22, 32'h11};
        step();
        for (int i = 0; i < 3; i++) begin
            set_hazard();
            id_rs_data = {32'h100 + i, 32'h200 + i};
            stall_in = 1;
            #1 check("hold_stall_out", stall_out, 0);
            step();
            check("hold_data", op_data, {32'h22, 32'h11});
            check("hold_valid", op_valid, 1);
            check("hold_tag", fwd_src, 0);
        end
        flush = 1;
        step();
        check("flush_valid", op_valid, 0);
        check("flush_data", op_data, 0);

        // LU_STALL is held by stall_in, then left by loading
        set_hazard();
        #1 check("pend_stall_req", stall_out, 1);
        step(); bump();
        stall_in = 1;
        #1 check("pend_hold_stall", stall_out, 0);
        step();
        check("pend_hold_valid", op_valid, 0);
        stall_in = 0;
        #1 check("pend_lu_no_stall", stall_out, 0);
        step();
        check("pend_lu_data", op_data, {32'h1234, 32'h10});
        check("pend_lu_tag", fwd_src, 4'b0100);
        check("pend_lu_valid", op_valid, 1);

        // flush with stall_in pending in LU_STALL returns to RUN
        #1 check("flush_pre_stall", stall_out, 1);
        step(); bump();
        stall_in = 1; flush = 1;
        #1 check("flush_stall_out", stall_out, 0);
        step();
        check("flush_lu_valid", op_valid, 0);
        stall_in = 0; flush = 0;
        #1 check("flush_to_run", stall_out, 1);
        check("count_sat_a", lu_stalls, exp_lu);

        // async reset in LU_STALL
        step();
        #3 reset = 0;
        #1;
        check("arst_count", lu_stalls, 0);
        check("arst_stall_out", stall_out, 0);
        check("arst_valid", op_valid, 0);
        #2 reset = 1;
        exp_lu = 0;
        clr();

        for (int i = 0; i < 5; i++) lu_event($sformatf("sat%0d", i));
        check("sat_final", lu_stalls, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_bypass.md
# operand_bypass

Parametrised operand-forwarding and load-use interlock for the ID/EX boundary of the 32I pipeline. It compares each decode-stage source register against in-flight destinations in EX, MEM and (optionally) WB and selects the youngest producer. It detects load-use hazards itself and issues a single-cycle decode stall. Forwarded operands are registered into the ID/EX operand slots, together with a valid bit and per-operand source tags.

## Interface
Parameters:
- XLEN, 32, datapath width.
- NSRC, 2, number of source operands per instruction (1..3).
- WB_FWD, 1, 1 = WB stage is a forwarding source; 0 = WB ignored (register file is write-first).
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs_addr  in  NSRC*5  source register numbers; operand i is at [5i+4:5i].
- id_rs_use  in  NSRC  operand i is actually read.
- id_rs_data  in  NSRC*XLEN  register-file read data.
- ex_valid, ex_wen, ex_is_load  in  1 each  EX-stage instruction status.
- ex_rd  in  5  EX destination register.
- ex_result  in  XLEN  EX result, already muxed (ALU or pc+4).
- mem_valid, mem_wen, mem_is_load  in  1 each  MEM-stage status.
- mem_rd  in  5  MEM destination register.
- mem_alu, mem_rdata  in  XLEN each  MEM ALU result and load data.
- wb_valid, wb_wen  in  1 each  WB status.
- wb_rd  in  5  WB destination register.
- wb_data  in  XLEN  WB write data.
- stall_in  in  1  downstream hold of ID/EX.
- flush  in  1  kill the instruction entering ID/EX.
- op_data  out  NSRC*XLEN  registered operands.
- op_valid  out  1  registered operands belong to a real instruction.
- fwd_src  out  NSRC*2  per-operand source tag: 0 regfile, 1 EX, 2 MEM, 3 WB.
- stall_out  out  1  combinational load-use stall request to IF/ID.
- lu_stalls  out  CNT_W  saturating count of load-use stalls.

## Operation
- Stage match for operand i requires all of: stage valid, stage wen, stage rd == id_rs_addr[i], rd != 0, and id_rs_use[i].
- Priority per operand is EX > MEM > WB > regfile; the youngest producer wins. The WB match is disabled when WB_FWD=0. Register x0 never forwards.
- Selected data per source:
  - EX: ex_result.
  - MEM: mem_rdata if mem_is_load, else mem_alu.
  - WB: wb_data.
  - Regfile: id_rs_data.
- Load-use: the hazard exists when any operand's winning source is EX and ex_is_load=1.
- FSM states: RUN and LU_STALL.
  - RUN: stall_out = hazard & id_valid & ~flush & ~stall_in.
    - When stall_out=1: load a bubble (op_valid←0, op_data←0, fwd_src←0), increment lu_stalls (saturating at 2^CNT_W−1), and go to LU_STALL.
    - Otherwise load the forwarded operands, with op_valid←id_valid.
  - LU_STALL: stall_out=0. The held instruction now sees the load in MEM and takes mem_rdata. Load the operands, then go to RUN.
- stall_in=1 (with flush=0): op_data, op_valid, fwd_src and the FSM state all hold. stall_out=0.
- flush=1 takes priority over stall_in and the hazard. op_valid←0, op_data←0, fwd_src←0, state←RUN, and stall_out=0.
- Operands are independent. Two operands naming the same register get identical data and tags.

## Timing
- Reset (asynchronous, reset=0): op_data=0, op_valid=0, fwd_src=0, lu_stalls=0, state=RUN. stall_out=0 while reset is asserted.
- Latency: inputs sampled at edge N appear on op_data, op_valid and fwd_src after edge N.
- stall_out is combinational, valid in the same cycle as the decode inputs. It is asserted for at most one cycle per load.
- A load-use hazard costs exactly one bubble. The operand appears two edges after the stalled instruction first presents.
- A reset asserted during LU_STALL returns the FSM to RUN. The pending bubble is lost, and that is acceptable.

## Test plan
- No hazard: id_rs_addr={x2,x1}, use=11, regfile data {0x22,0x11}, all stages invalid -> next cycle op_data={0x22,0x11}, fwd_src={0,0}, op_valid=1.
- Priority: x5 is written in EX (0xA), MEM (0xB) and WB (0xC); operand0=x5 -> op_data0=0xA, tag 1. With EX invalid -> 0xB, tag 2. With WB_FWD=0 and only WB matching -> the regfile value.
- x0 guard: ex_rd=0, ex_wen=1, id_rs_addr0=0, regfile 0 -> op_data0=0, tag 0.
- Load-use: EX holds a load to x7 and operand1=x7 -> stall_out=1, bubble (op_valid=0), lu_stalls=1. Next cycle mem_is_load, mem_rdata=0xDEAD -> op_data1=0xDEAD, tag 2, stall_out=0.
- stall_in/flush: stall_in=1 for 3 cycles with changing inputs -> outputs frozen. Then flush with stall_in=1 -> op_valid=0 on the next edge, and a pending LU_STALL returns to RUN.
- Counter saturation: CNT_W=2 with 5 load-use events -> lu_stalls saturates at 3.
